serial_sub_ctrl: RTL
====================

// Module: serial_sub_ctrl
// PURPOSE
//   Bit-serial subtraction controller. Sequences a single 1-bit subtractor cell
//   (two half_sub stages plus an OR on the borrows) over a WIDTH-bit operand
//   pair, LSB first, holding the running borrow in a flop.
//   Computes diff = a - b and the final borrow. Trades WIDTH cycles of latency
//   for a single shared subtractor cell.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range >= 2
// PORTS
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; sampled on clk only while busy==0
//   a      in   WIDTH  minuend; captured on the accepted start edge
//   b      in   WIDTH  subtrahend; captured on the accepted start edge
//   busy   out  1      high while state==RUN
//   done   out  1      one-cycle pulse: diff/borr valid
//   diff   out  WIDTH  result register; holds its value until the next done
//   borr   out  1      final borrow out of the MSB (1 when a < b unsigned)
// BEHAVIOUR
//   - Reset: state=IDLE, busy=0, done=0, diff=0, borr=0, shift regs=0,
//     borrow flop=0, bit count=0.
//   - rst mid-operation aborts the operation and has the same effect as reset.
//     No done pulse follows.
//   - FSM states: IDLE, RUN, DONE.
//     - IDLE  -> RUN : start==1.
//     - RUN   -> DONE: after the WIDTH-th bit is processed.
//     - DONE  -> RUN : start==1 (back-to-back operation).
//     - DONE  -> IDLE: otherwise.
//   - Accept edge E0 (start==1 while busy==0):
//     - load a and b into internal shift regs;
//     - clear the borrow flop and the bit count;
//     - enter RUN.
//   - RUN edges E1..EWIDTH: one bit per edge. For k = count:
//     - d_k  = a_k ^ b_k ^ bin;
//     - bout = (~a_k & b_k) | (~(a_k ^ b_k) & bin);
//     - shift d_k into the result shift reg MSB side; bin <= bout; count++.
//   - Edge EWIDTH: state <= DONE, diff <= assembled result,
//     borr <= final bout.
//   - done is high exactly one cycle, the cycle after EWIDTH.
//     Latency: start sampled -> done high = WIDTH+1 cycles.
//   - busy=1 in the cycles following E0 through EWIDTH; busy=0 in DONE and IDLE.
//   - start while busy==1 is ignored: no restart, a and b are not re-sampled.
//   - a and b may change freely after E0 without affecting the result.
//   - diff and borr are updated only on the RUN->DONE edge. Intermediate bits
//     are never visible on diff.
//   - Arithmetic is modulo 2^WIDTH. The bit count is $clog2(WIDTH)+1 bits wide,
//     with no wrap inside a legal operation.
// CONFIGURATION
//   SERSUB_SAT_EN defined:
//     - when the final borrow is 1, diff <= 0 (unsigned floor saturation);
//     - borr still reports 1;
//     - timing is unchanged.
//   SERSUB_SAT_EN undefined:
//     - diff is the two's-complement wrapped result;
//     - borr is as above.
// TESTING (WIDTH=4)
//   1. a=5, b=3, start 1 cycle -> done 5 cycles later; diff=2, borr=0;
//      busy high for exactly 4 cycles.
//   2. a=3, b=5 -> diff=4'hE, borr=1. With SERSUB_SAT_EN: diff=0, borr=1.
//   3. a=0, b=0 -> diff=0, borr=0. Then a=F, b=0 -> diff=F, borr=0.
//   4. start=1 held continuously, a=9, b=4, with a/b changed to 1/1 after
//      acceptance -> diff=5, borr=0. Next op begins from the DONE cycle
//      (back-to-back); no start is accepted during RUN.
//   5. a=7, b=2, assert rst on the 2nd RUN cycle -> next cycle busy=0, done=0,
//      diff=0, borr=0. No done pulse follows. A new op a=6, b=6 gives diff=0,
//      borr=0.
//   6. done is a 1-cycle pulse; diff and borr hold the previous result through
//      a following idle period and throughout the next RUN.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// ============================================================================
// Module   : serial_sub_ctrl
// Brief    : Bit-serial a - b using one shared 1-bit subtractor cell, LSB first.
//            Optional unsigned floor saturation when SERSUB_SAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_bin;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borr;

  logic             w_accept;
  logic             w_last;
  logic             w_hd;
  logic             w_hb;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_final;

  // Two cascaded half subtractors; the borrows are ORed into the cell's bout.
  always_comb begin
    w_hd   = r_a[0] ^ r_b[0];
    w_hb   = ~r_a[0] & r_b[0];
    w_d    = w_hd ^ r_bin;
    w_bout = w_hb | (~w_hd & r_bin);
  end

  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

`ifdef SERSUB_SAT_EN
  assign w_final = w_bout ? '0 : w_res_next;
`else
  assign w_final = w_res_next;
`endif

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_cnt == c_last);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_bin  <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_borr <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_res <= '0;
      r_bin <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= w_res_next;
      r_bin <= w_bout;
      r_cnt <= r_cnt + 1'b1;
      // Result registers move only on the final bit so partial sums stay hidden.
      if (w_last) begin
        r_diff <= w_final;
        r_borr <= w_bout;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign diff = r_diff;
  assign borr = r_borr;

endmodule

`default_nettype wire
